pr_fetch_ctrl: RTL and testbench
================================

PR_FETCH_CTRL -- requirements
Module: pr_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, meaning DDR application address width.
REQ-002 SHALL have parameter LEN_W, default 20, meaning width of the bitstream length in 256-bit beats.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 16, meaning the maximum number of read commands accepted but not yet answered.
REQ-004 SHALL have parameter ADDR_STEP, default 8, meaning the address increment per 256-bit beat.
REQ-005 i_clk  input  1  single clock for all logic; the block has one clock and the reset is asynchronous, active-high.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_start  input  1  one-cycle pulse that launches a fetch.
REQ-008 i_base_addr  input  ADDR_W  first beat address, sampled on an accepted start.
REQ-009 i_length  input  LEN_W  beat count, sampled on an accepted start.
REQ-010 o_app_en, o_app_cmd[2:0], o_app_addr[ADDR_W-1:0]  output  DDR command request, read opcode, and beat address.
REQ-011 i_app_rdy  input  1  DDR controller accepts the command when high with o_app_en.
REQ-012 i_app_rd_data[255:0], i_app_rd_data_valid  input  read return beat and its strobe.
REQ-013 o_ddr_data[255:0], o_ddr_data_valid  output  beat stream to the configuration buffer writer.
REQ-014 i_config_buff_full  input  1  downstream almost-full; gates new commands only.
REQ-015 o_busy, o_done, o_error  output  1 each  fetch active; one-cycle completion pulse; sticky fault.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 IDLE: i_start SHALL latch base and length, clear o_error, and go to ISSUE; if length is 0, it SHALL go to DONE instead.
REQ-018 i_start outside IDLE SHALL be ignored with no side effect.
REQ-019 ISSUE SHALL raise o_app_en with o_app_cmd=3'b001 only when outstanding<MAX_OUTSTANDING and i_config_buff_full=0.
REQ-020 Once raised, o_app_en, o_app_addr and o_app_cmd SHALL hold stable until accepted (o_app_en & i_app_rdy), regardless of full or credit changes.
REQ-021 On acceptance, o_app_addr SHALL advance by ADDR_STEP, modulo 2^ADDR_W (wrap permitted, no error).
REQ-022 Back-to-back acceptance on consecutive cycles SHALL be supported when gating conditions allow.
REQ-023 After the last command is accepted, the FSM SHALL go to DRAIN with o_app_en low on the next cycle.
REQ-024 The outstanding counter SHALL increment on acceptance, decrement on a response, and stay unchanged when both occur in the same cycle; its width SHALL be clog2(MAX_OUTSTANDING+1).
REQ-025 DRAIN SHALL go to DONE when the response count equals the latched length.
REQ-026 DONE SHALL pulse o_done for exactly one cycle, then return to IDLE.
REQ-027 o_busy SHALL be high in ISSUE and DRAIN and low otherwise.
REQ-028 Every response SHALL appear on o_ddr_data/o_ddr_data_valid exactly one cycle later, unmodified and in order, with no bubbles added.
REQ-029 A response received in IDLE or DONE, or when outstanding is 0, SHALL be forwarded, SHALL leave the counters unchanged, and SHALL set o_error.
REQ-030 i_config_buff_full SHALL never suppress forwarding of returning data.

Reset
REQ-031 Assertion of i_rst SHALL immediately force IDLE, all counters to 0, o_app_en=0, o_app_addr=0, o_app_cmd=3'b001, o_ddr_data=0, o_ddr_data_valid=0, o_busy=0, o_done=0 and o_error=0.
REQ-032 A reset during a fetch SHALL abandon the fetch; late responses after release SHALL be handled per REQ-029.

Structure
REQ-033 Package pr_fetch_pkg SHALL hold the state enumeration, the APP_CMD_READ constant (3'b001) and the default ADDR_STEP.
REQ-034 No sub-module SHALL be used; the FSM, address counter, credit counter and output register SHALL be in one module.

Verification
REQ-035 Start with base=0x100 and length=4, i_app_rdy=1, and responses 5 cycles after each accept: addresses 0x100, 0x108, 0x110, 0x118 accepted on consecutive cycles, 4 beats forwarded with 1-cycle latency, o_done one pulse after beat 4.
REQ-036 i_app_rdy low for 3 cycles while o_app_en is high: address and command held constant, exactly one accept.
REQ-037 MAX_OUTSTANDING=16, length=40, no responses: exactly 16 accepts, then o_app_en stays low until a response arrives.
REQ-038 i_config_buff_full high mid-fetch while a command is pending: the pending command completes, no further commands issue, responses keep flowing, and issuing resumes after full drops.
REQ-039 length=0 start: o_done pulses 2 cycles after the start cycle with no command issued; a second start while busy is ignored.
REQ-040 i_rst asserted with 3 commands outstanding: all outputs are at reset values immediately, and a late response after release is forwarded and sets o_error=1.

Source files
------------

// File: rtl/pr_fetch_pkg.sv
// Shared definitions for the partial-reconfiguration bitstream fetch controller:
// FSM encoding, DDR read opcode and default beat address stride.
package pr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    localparam logic [2:0] APP_CMD_READ      = 3'b001;
    localparam int         DEFAULT_ADDR_STEP = 8;

endpackage

// File: rtl/pr_fetch_ctrl.sv
// Streams a bitstream out of DDR: issues credit-limited read commands, forwards
// returning beats one cycle later and flags responses nobody asked for.
module pr_fetch_ctrl
    import pr_fetch_pkg::*;
#(
    parameter int ADDR_W          = 27,
    parameter int LEN_W           = 20,
    parameter int MAX_OUTSTANDING = 16,
    parameter int ADDR_STEP       = DEFAULT_ADDR_STEP
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_app_en,
    output logic [2:0]        o_app_cmd,
    output logic [ADDR_W-1:0] o_app_addr,
    input  logic              i_app_rdy,
    input  logic [255:0]      i_app_rd_data,
    input  logic              i_app_rd_data_valid,
    output logic [255:0]      o_ddr_data,
    output logic              o_ddr_data_valid,
    input  logic              i_config_buff_full,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t      state_reg;
    logic              app_en_reg;
    logic [2:0]        app_cmd_reg;
    logic [ADDR_W-1:0] app_addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issue_cnt_reg;
    logic [LEN_W-1:0]  resp_cnt_reg;
    logic [OUT_W-1:0]  outst_reg;
    logic [255:0]      ddr_data_reg;
    logic              ddr_valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;

    logic              accept;
    logic              resp_counted;
    logic              resp_stray;
    logic              credit_ok;
    logic [OUT_W-1:0]  outst_next;
    logic [LEN_W-1:0]  issue_cnt_next;
    logic [LEN_W-1:0]  resp_cnt_next;

    // A response only counts against a fetch that actually has reads in flight.
    always_comb begin
        accept         = app_en_reg & i_app_rdy;
        resp_counted   = i_app_rd_data_valid
                         && (state_reg == ST_ISSUE || state_reg == ST_DRAIN)
                         && (outst_reg != '0);
        resp_stray     = i_app_rd_data_valid & ~resp_counted;
        outst_next     = outst_reg;
        if (accept && !resp_counted) begin
            outst_next = outst_reg + 1'b1;
        end else if (!accept && resp_counted) begin
            outst_next = outst_reg - 1'b1;
        end
        credit_ok      = (outst_next < OUT_W'(MAX_OUTSTANDING)) && !i_config_buff_full;
        issue_cnt_next = issue_cnt_reg + 1'b1;
        resp_cnt_next  = resp_cnt_reg + LEN_W'(resp_counted);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            app_en_reg    <= 1'b0;
            app_cmd_reg   <= APP_CMD_READ;
            app_addr_reg  <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            resp_cnt_reg  <= '0;
            outst_reg     <= '0;
            ddr_data_reg  <= '0;
            ddr_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            ddr_data_reg  <= i_app_rd_data;
            ddr_valid_reg <= i_app_rd_data_valid;
            outst_reg     <= outst_next;
            resp_cnt_reg  <= resp_cnt_next;
            done_reg      <= 1'b0;
            if (resp_stray) begin
                error_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        len_reg       <= i_length;
                        app_addr_reg  <= i_base_addr;
                        issue_cnt_reg <= '0;
                        resp_cnt_reg  <= '0;
                        if (!resp_stray) begin
                            error_reg <= 1'b0;
                        end
                        if (i_length == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_ISSUE;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A raised request is frozen until the controller takes it.
                    if (app_en_reg) begin
                        if (i_app_rdy) begin
                            app_addr_reg  <= app_addr_reg + ADDR_W'(ADDR_STEP);
                            issue_cnt_reg <= issue_cnt_next;
                            if (issue_cnt_next == len_reg) begin
                                app_en_reg <= 1'b0;
                                state_reg  <= ST_DRAIN;
                            end else begin
                                app_en_reg <= credit_ok;
                            end
                        end
                    end else begin
                        app_en_reg  <= credit_ok;
                        app_cmd_reg <= APP_CMD_READ;
                    end
                end
                ST_DRAIN: begin
                    if (resp_cnt_next == len_reg) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_app_en         = app_en_reg;
    assign o_app_cmd        = app_cmd_reg;
    assign o_app_addr       = app_addr_reg;
    assign o_ddr_data       = ddr_data_reg;
    assign o_ddr_data_valid = ddr_valid_reg;
    assign o_busy           = busy_reg;
    assign o_done           = done_reg;
    assign o_error          = error_reg;

endmodule

// File: tb/tb_pr_fetch_ctrl.sv
// Scoreboard bench for pr_fetch_ctrl: a DDR responder model answers accepted
// reads, expected addresses and beats are queued and checked as they appear.
module tb_pr_fetch_ctrl;

    localparam int ADDR_W = 27;
    localparam int LEN_W  = 20;

    typedef struct {
        logic [255:0] data;
        int           cyc;
    } beat_t;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [LEN_W-1:0]  i_length;
    logic              o_app_en;
    logic [2:0]        o_app_cmd;
    logic [ADDR_W-1:0] o_app_addr;
    logic              i_app_rdy;
    logic [255:0]      i_app_rd_data;
    logic              i_app_rd_data_valid;
    logic [255:0]      o_ddr_data;
    logic              o_ddr_data_valid;
    logic              i_config_buff_full;
    logic              o_busy;
    logic              o_done;
    logic              o_error;

    pr_fetch_ctrl #(
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .MAX_OUTSTANDING(16),
        .ADDR_STEP(8)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_length(i_length),
        .o_app_en(o_app_en),
        .o_app_cmd(o_app_cmd),
        .o_app_addr(o_app_addr),
        .i_app_rdy(i_app_rdy),
        .i_app_rd_data(i_app_rd_data),
        .i_app_rd_data_valid(i_app_rd_data_valid),
        .o_ddr_data(o_ddr_data),
        .o_ddr_data_valid(o_ddr_data_valid),
        .i_config_buff_full(i_config_buff_full),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    int                pend_due[$];
    int                acc_cycs[$];
    beat_t             exp_beats[$];

    int accepts       = 0;
    int beats         = 0;
    int dones         = 0;
    int done_cyc      = 0;
    int last_beat_cyc = 0;
    int resp_delay    = 5;
    bit resp_hold     = 1'b0;
    int stray_cnt     = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // DDR responder: one beat per cycle, stray beats take priority.
    int stray_done = 0;
    always @(posedge i_clk) begin
        logic [255:0] d;
        #2;
        if (stray_done != stray_cnt || (!resp_hold && pend_due.size() > 0 && pend_due[0] <= cyc)) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
            i_app_rd_data       = d;
            i_app_rd_data_valid = 1'b1;
            exp_beats.push_back('{data: d, cyc: cyc});
            if (stray_done != stray_cnt) stray_done++;
            else void'(pend_due.pop_front());
        end else begin
            i_app_rd_data_valid = 1'b0;
        end
    end

    // Monitor: commands, forwarded beats and done pulses, mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst && o_app_en && i_app_rdy) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_accept", o_app_en, 1'b0);
            end else begin
                chk("app_addr", o_app_addr, exp_addr.pop_front());
            end
            chk("app_cmd", o_app_cmd, 3'b001);
            $display("accept  cyc=%0d addr=%0h", cyc, o_app_addr);
            accepts++;
            acc_cycs.push_back(cyc);
            pend_due.push_back(cyc + resp_delay);
        end
        if (o_ddr_data_valid) begin
            if (exp_beats.size() == 0) begin
                chk("unexpected_beat", o_ddr_data_valid, 1'b0);
            end else begin
                beat_t b;
                b = exp_beats.pop_front();
                chk("beat_data", o_ddr_data, b.data);
                chk("beat_latency", cyc, b.cyc + 1);
            end
            $display("beat    cyc=%0d data=%0h", cyc, o_ddr_data[31:0]);
            beats++;
            last_beat_cyc = cyc;
        end
        if (o_done) begin
            $display("done    cyc=%0d", cyc);
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_fetch(input logic [ADDR_W-1:0] base, input int len, output int start_cyc);
        for (int i = 0; i < len; i++) exp_addr.push_back(base + ADDR_W'(8 * i));
        i_base_addr = base;
        i_length    = LEN_W'(len);
        i_start     = 1'b1;
        start_cyc   = cyc;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int bound);
        int n = 0;
        while (dones == d0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, dones - d0, 1);
    endtask

    task automatic wait_en(input string tag, input int bound);
        int n = 0;
        while (!o_app_en && n < bound) begin
            tick();
            n++;
        end
        chk(tag, o_app_en, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b0, d0, s;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_length = '0;
        i_app_rdy = 1'b0;
        i_config_buff_full = 1'b0;
        i_app_rd_data = '0;
        i_app_rd_data_valid = 1'b0;
        repeat (3) tick();
        chk("rst_app_en", o_app_en, 1'b0);
        chk("rst_app_cmd", o_app_cmd, 3'b001);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_error", o_error, 1'b0);
        i_rst = 1'b0;
        tick();

        // Basic fetch with back-to-back accepts.
        i_app_rdy = 1'b1; resp_delay = 5;
        a0 = accepts; b0 = beats; d0 = dones;
        acc_cycs.delete();
        start_fetch(27'h100, 4, s);
        tick();
        chk("busy_issue", o_busy, 1'b1);
        wait_done("t035_done", d0, 100);
        chk("t035_accepts", accepts - a0, 4);
        chk("t035_consecutive", acc_cycs[3] - acc_cycs[0], 3);
        chk("t035_beats", beats - b0, 4);
        chk("t035_done_after_beat", done_cyc, last_beat_cyc + 1);
        tick(); tick();
        chk("t035_one_done", dones - d0, 1);
        chk("t035_busy_low", o_busy, 1'b0);
        chk("t035_error", o_error, 1'b0);

        // Controller stall: request held for 3 cycles.
        i_app_rdy = 1'b0;
        a0 = accepts; d0 = dones;
        start_fetch(27'h200, 1, s);
        wait_en("t036_en", 10);
        for (int i = 0; i < 3; i++) begin
            chk("t036_en_held", o_app_en, 1'b1);
            chk("t036_addr_held", o_app_addr, 27'h200);
            chk("t036_cmd_held", o_app_cmd, 3'b001);
            tick();
        end
        chk("t036_no_accept", accepts - a0, 0);
        i_app_rdy = 1'b1;
        wait_done("t036_done", d0, 100);
        chk("t036_accepts", accepts - a0, 1);

        // Credit limit with responses withheld.
        resp_hold = 1'b1;
        a0 = accepts; d0 = dones;
        start_fetch(27'h1000, 40, s);
        repeat (30) tick();
        chk("t037_accepts_16", accepts - a0, 16);
        for (int i = 0; i < 6; i++) begin
            chk("t037_en_low", o_app_en, 1'b0);
            tick();
        end
        resp_hold = 1'b0;
        wait_done("t037_done", d0, 400);
        chk("t037_accepts_40", accepts - a0, 40);
        chk("t037_error", o_error, 1'b0);

        // Buffer full while a command is pending.
        resp_delay = 3; i_app_rdy = 1'b0;
        a0 = accepts; b0 = beats; d0 = dones;
        start_fetch(27'h2000, 8, s);
        wait_en("t038_en", 10);
        i_config_buff_full = 1'b1;
        tick(); tick();
        chk("t038_pending_held", o_app_en, 1'b1);
        i_app_rdy = 1'b1;
        repeat (10) tick();
        chk("t038_one_accept", accepts - a0, 1);
        chk("t038_beat_flowed", beats - b0, 1);
        chk("t038_en_gated", o_app_en, 1'b0);
        i_config_buff_full = 1'b0;
        wait_done("t038_done", d0, 200);
        chk("t038_accepts", accepts - a0, 8);

        // Zero length, then a start while busy.
        a0 = accepts; d0 = dones;
        start_fetch(27'h3000, 0, s);
        repeat (4) tick();
        chk("t039_zero_done", dones - d0, 1);
        chk("t039_done_cycle", done_cyc - s, 2);
        chk("t039_no_cmd", accepts - a0, 0);
        d0 = dones;
        start_fetch(27'h4000, 4, s);
        tick();
        i_base_addr = 27'h9000; i_length = '0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done("t039_busy_done", d0, 100);
        repeat (4) tick();
        chk("t039_ignored_start", dones - d0, 1);
        chk("t039_accepts", accepts - a0, 4);

        // Reset with 3 reads outstanding, then a late response.
        resp_hold = 1'b1; i_app_rdy = 1'b0;
        a0 = accepts; b0 = beats;
        start_fetch(27'h5000, 10, s);
        wait_en("t040_en", 10);
        i_app_rdy = 1'b1;
        repeat (3) tick();
        i_app_rdy = 1'b0;
        chk("t040_three_out", accepts - a0, 3);
        #3 i_rst = 1'b1;
        #1;
        chk("t040_rst_en", o_app_en, 1'b0);
        chk("t040_rst_addr", o_app_addr, 27'h0);
        chk("t040_rst_cmd", o_app_cmd, 3'b001);
        chk("t040_rst_data", o_ddr_data, 256'h0);
        chk("t040_rst_valid", o_ddr_data_valid, 1'b0);
        chk("t040_rst_busy", o_busy, 1'b0);
        chk("t040_rst_done", o_done, 1'b0);
        chk("t040_rst_error", o_error, 1'b0);
        pend_due.delete();
        exp_addr.delete();
        tick();
        i_rst = 1'b0;
        tick();
        b0 = beats;
        stray_cnt++;
        repeat (3) tick();
        chk("t040_late_fwd", beats - b0, 1);
        chk("t040_late_error", o_error, 1'b1);
        chk("t040_idle_busy", o_busy, 1'b0);

        // A new start clears the sticky error.
        resp_hold = 1'b0; i_app_rdy = 1'b1;
        d0 = dones;
        start_fetch(27'h40, 1, s);
        tick();
        chk("err_cleared", o_error, 1'b0);
        wait_done("final_done", d0, 100);
        repeat (3) tick();
        chk("addr_q_empty", exp_addr.size(), 0);
        chk("beat_q_empty", exp_beats.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
